instr_fetch_buffer: RTL and testbench
=====================================

# instr_fetch_buffer

Fetch stage directly downstream of `Program_counter`. It takes the current PC, issues single-word reads to instruction memory, and queues {pc, instruction} pairs in a small FIFO for decode. It pulses `fetch_ack` so the next-PC logic advances the PC only after that address has been fetched. A `flush` discards queued and in-flight instructions on branch or jump redirect.

## Interface
Parameters:
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: instruction width.
- `DEPTH`, 4: FIFO entries. Must be a power of two and ≥2.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `pc_addr` in ADDR_W: current PC, i.e. `Program_counter.Out_Addr`.
- `fetch_ack` out 1: one-cycle pulse; `pc_addr` has been issued and the PC may advance.
- `flush` in 1: redirect; discard all buffered and in-flight instructions.
- `mem_req` out 1: one-cycle read request.
- `mem_addr` out ADDR_W: read address, valid while `mem_req`=1; holds its value until the next request.
- `mem_rvalid` in 1: read data valid, at least 1 cycle after `mem_req`.
- `mem_rdata` in DATA_W: instruction word.
- `dec_valid` out 1: FIFO head valid.
- `dec_instr` out DATA_W: head instruction; 0 when empty.
- `dec_pc` out ADDR_W: head PC; 0 when empty.
- `dec_ready` in 1: decode accepts the head.
- `fifo_count` out $clog2(DEPTH)+1: occupied entries.

## Operation
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: one request outstanding.
  - DROP: one request outstanding, and its response will be discarded.
- IDLE, `flush`=0, `fifo_count`<DEPTH: at the clock edge, register `mem_req`=1, `mem_addr`=`pc_addr` and `fetch_ack`=1, then go to WAIT. Otherwise stay in IDLE with `mem_req`=0.
- WAIT, `mem_rvalid`=1, `flush`=0:
  - Push {`mem_addr`, `mem_rdata`}.
  - If `fifo_count`+1<DEPTH, issue the next request on the same edge (back-to-back) and stay in WAIT.
  - Otherwise go to IDLE.
- WAIT, `flush`=1, `mem_rvalid`=0: go to DROP.
- WAIT, `flush`=1, `mem_rvalid`=1: discard the response and go to IDLE.
- DROP, `mem_rvalid`=1: discard the response and go to IDLE. A further `flush` while in DROP keeps the state at DROP.
- `flush` (any state): FIFO emptied at the edge. Flush takes priority over push and pop. No request is issued in a flush cycle.
- Pop on `dec_valid` & `dec_ready`. Simultaneous push and pop leaves the count unchanged.
- Overflow cannot occur, because a request is issued only when a slot is guaranteed.
- FIFO pointers have ADDR bits $clog2(DEPTH) and wrap modulo DEPTH.
- `mem_rvalid` in IDLE is a protocol error and is ignored (no push).
- At most one request is outstanding at any time.
- `dec_valid` = (`fifo_count`≠0). `dec_instr`/`dec_pc` are the head entry, gated to 0 when empty.

## Timing
- Reset (asynchronous, immediate):
  - state = IDLE.
  - FIFO empty, `fifo_count`=0.
  - `mem_req`=0, `fetch_ack`=0, `mem_addr`=0.
  - `dec_valid`=0, `dec_instr`=0, `dec_pc`=0.
- After reset release, the first rising edge issues the request: `mem_req`/`fetch_ack` are high in cycle 1.
- `mem_req` and `fetch_ack` are registered and high for exactly one cycle per request.
- The PC updates on the edge ending the `fetch_ack` cycle, so `pc_addr` is new by the next possible issue.
- With `mem_req` in cycle c and `mem_rvalid` in cycle c+L (L≥1):
  - Push happens at the end of c+L.
  - `dec_valid` rises in c+L+1.
  - The next `mem_req` is in c+L+1 if space allows.
  - Peak throughput is one instruction per L+1 cycles.
- Decode latency: from `mem_rvalid` to `dec_valid` is 1 cycle.
- Pop: the head changes, or `dec_valid` falls, in the cycle after the accepting edge.
- Reset asserted mid-WAIT: the outstanding response is forgotten, and a later `mem_rvalid` arrives in IDLE and is ignored.

## Test plan
- **Reset and single fetch.** Stimulus: `pc_addr`=0x0, L=1, `mem_rdata`=0x20020005, `dec_ready`=0. Response: `mem_req`/`fetch_ack` in cycle 1 with `mem_addr`=0x0; `dec_valid`=1 in cycle 3 with `dec_instr`=0x20020005, `dec_pc`=0x0, `fifo_count`=1.
- **Streaming.** Stimulus: L=1, `dec_ready`=1, PC advances by +4 on each `fetch_ack`. Response: a request every 2 cycles; `dec_pc` sequence 0x0, 0x4, 0x8, 0xC in order, with no gaps or duplicates.
- **Fill/backpressure.** Stimulus: DEPTH=4, `dec_ready`=0. Response: exactly 4 requests; `fifo_count`=4 and `mem_req` held low. A single-cycle `dec_ready` produces exactly one further request.
- **Flush during WAIT.** Stimulus: L=3, `flush` in the cycle after `mem_req`, PC redirected to 0x40. Response: FIFO empty at once; the old response is not pushed; the next `mem_req` has `mem_addr`=0x40 and is issued only after the dropped `mem_rvalid`.
- **Simultaneous flush, rvalid and pop.** Stimulus: FIFO holds 2 entries. Response: `fifo_count`=0 next cycle, nothing pushed, state IDLE.
- **Reset mid-operation.** Stimulus: `rst_n` low in WAIT; stray `mem_rvalid` arrives after release. Response: outputs are 0 immediately; the stray response is ignored; a fresh request is issued on the first edge after release.

Source files
------------

// File: rtl/instr_fetch_buffer_if.sv
//------------------------------------------------------------------------------
// instr_fetch_buffer_if
// PC, instruction-memory and decode-side signals of the instruction fetch buffer.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface instr_fetch_buffer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] pc_addr;
    logic              fetch_ack;
    logic              flush;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic              dec_valid;
    logic [DATA_W-1:0] dec_instr;
    logic [ADDR_W-1:0] dec_pc;
    logic              dec_ready;
    logic [CNT_W-1:0]  fifo_count;

    // The fetch buffer drives the bus; the PC, memory and decode stages sit on the slave side.
    modport master (
        input  pc_addr, flush, mem_rvalid, mem_rdata, dec_ready,
        output fetch_ack, mem_req, mem_addr, dec_valid, dec_instr, dec_pc, fifo_count
    );

    modport slave (
        output pc_addr, flush, mem_rvalid, mem_rdata, dec_ready,
        input  fetch_ack, mem_req, mem_addr, dec_valid, dec_instr, dec_pc, fifo_count
    );
endinterface

`default_nettype wire

// File: rtl/instr_fetch_buffer.sv
//------------------------------------------------------------------------------
// instr_fetch_buffer
// Issues single-word instruction reads for the current PC and queues
// {pc, instruction} pairs for decode; flush drops queued and in-flight words.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module instr_fetch_buffer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    instr_fetch_buffer_if.master   bus
);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W:0] c_DEPTH_X = (c_CNT_W + 1)'(DEPTH);

    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("instr_fetch_buffer: DEPTH must be a power of two and >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t              state_q;
    logic                mem_req_q;
    logic                fetch_ack_q;
    logic [ADDR_W-1:0]   mem_addr_q;

    logic [ADDR_W-1:0]   pc_mem_q    [DEPTH];
    logic [DATA_W-1:0]   instr_mem_q [DEPTH];
    logic [c_PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [c_CNT_W-1:0]  count_q,  count_d;

    logic                w_push;
    logic                w_pop;
    logic                w_not_empty;
    logic [c_CNT_W:0]    w_occ;
    logic                w_issue;

    assign w_not_empty = (count_q != '0);
    assign w_push      = (state_q == ST_WAIT) && bus.mem_rvalid && !bus.flush;
    assign w_pop       = w_not_empty && bus.dec_ready && !bus.flush;

    // A new request needs a free slot counting the word landing this cycle;
    // a pop in the same cycle is deliberately not credited.
    assign w_occ   = {1'b0, count_q} + {{c_CNT_W{1'b0}}, w_push};
    assign w_issue = !bus.flush
                   && ((state_q == ST_IDLE) || ((state_q == ST_WAIT) && bus.mem_rvalid))
                   && (w_occ < c_DEPTH_X);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            fetch_ack_q <= 1'b0;
            mem_addr_q  <= '0;
        end else begin
            mem_req_q   <= w_issue;
            fetch_ack_q <= w_issue;
            if (w_issue) begin
                mem_addr_q <= bus.pc_addr;
            end
            case (state_q)
                ST_IDLE: begin
                    if (w_issue) begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.flush) begin
                        state_q <= bus.mem_rvalid ? ST_IDLE : ST_DROP;
                    end else if (bus.mem_rvalid) begin
                        state_q <= w_issue ? ST_WAIT : ST_IDLE;
                    end
                end
                ST_DROP: begin
                    if (bus.mem_rvalid) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + c_PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + c_CNT_W'(1);
                2'b01:   count_d = count_q - c_CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset: reads are gated by the occupancy count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            pc_mem_q[wr_ptr_q]    <= mem_addr_q;
            instr_mem_q[wr_ptr_q] <= bus.mem_rdata;
        end
    end

    assign bus.mem_req    = mem_req_q;
    assign bus.fetch_ack  = fetch_ack_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.fifo_count = count_q;
    assign bus.dec_valid  = w_not_empty;
    assign bus.dec_instr  = w_not_empty ? instr_mem_q[rd_ptr_q] : '0;
    assign bus.dec_pc     = w_not_empty ? pc_mem_q[rd_ptr_q]    : '0;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_buffer.sv
//------------------------------------------------------------------------------
// tb_instr_fetch_buffer
// Randomised and directed stimulus checked against a queue-based fetch model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_instr_fetch_buffer;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    instr_fetch_buffer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    instr_fetch_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        mq[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_req    = 0;

    // Reference model: outstanding-request bookkeeping plus an ordered queue.
    bit          m_out, m_drop, m_req;
    int          m_wait;
    logic [31:0] m_addr;
    logic [31:0] pc;
    logic [31:0] redirect_pc;

    int          p_flush, p_ready, p_stray, lat_lo, lat_hi;
    bit          f_flush, f_ready, f_stray, fix_data, rand_redirect;
    logic [31:0] fixed_rdata;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_mem_req"},    64'(bus.mem_req),    64'd0);
        check_eq({tag, "_fetch_ack"},  64'(bus.fetch_ack),  64'd0);
        check_eq({tag, "_mem_addr"},   64'(bus.mem_addr),   64'd0);
        check_eq({tag, "_dec_valid"},  64'(bus.dec_valid),  64'd0);
        check_eq({tag, "_dec_instr"},  64'(bus.dec_instr),  64'd0);
        check_eq({tag, "_dec_pc"},     64'(bus.dec_pc),     64'd0);
        check_eq({tag, "_fifo_count"}, 64'(bus.fifo_count), 64'd0);
    endtask

    task automatic model_reset();
        mq.delete();
        m_out  = 1'b0;
        m_drop = 1'b0;
        m_req  = 1'b0;
        m_wait = 0;
        m_addr = '0;
    endtask

    function automatic bit chance(input int pct);
        return int'($urandom_range(0, 99)) < pct;
    endfunction

    // Called at a falling edge: check this cycle's outputs, drive inputs, advance model.
    task automatic do_cycle();
        logic [31:0] exp_pc, exp_instr, rd, pc_next;
        bit          fl, rdy, rv, pop, acc, issue;

        exp_pc    = (mq.size() != 0) ? mq[0].pc    : 32'd0;
        exp_instr = (mq.size() != 0) ? mq[0].instr : 32'd0;
        check_eq("mem_req",    64'(bus.mem_req),    64'(m_req));
        check_eq("fetch_ack",  64'(bus.fetch_ack),  64'(m_req));
        check_eq("mem_addr",   64'(bus.mem_addr),   64'(m_addr));
        check_eq("fifo_count", 64'(bus.fifo_count), 64'(mq.size()));
        check_eq("dec_valid",  64'(bus.dec_valid),  64'(mq.size() != 0));
        check_eq("dec_pc",     64'(bus.dec_pc),     64'(exp_pc));
        check_eq("dec_instr",  64'(bus.dec_instr),  64'(exp_instr));
        if (bus.mem_req === 1'b1) n_req++;

        fl  = f_flush || chance(p_flush);
        rdy = f_ready || chance(p_ready);
        if (m_out) rv = (m_wait == 0);
        else       rv = f_stray || chance(p_stray);
        rd  = fix_data ? fixed_rdata : $urandom;
        f_flush = 1'b0;
        f_ready = 1'b0;
        f_stray = 1'b0;
        if (rand_redirect) redirect_pc = 32'($urandom_range(0, 255)) << 2;

        bus.pc_addr    = pc;
        bus.flush      = fl;
        bus.dec_ready  = rdy;
        bus.mem_rvalid = rv;
        bus.mem_rdata  = rd;

        pop   = (mq.size() != 0) && rdy && !fl;
        acc   = rv && m_out && !m_drop && !fl;
        issue = !fl && !(m_out && !rv) && !(m_out && m_drop)
              && ((mq.size() + (acc ? 1 : 0)) < DEPTH);

        if (fl) begin
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (acc) mq.push_back(ent_t'{pc: m_addr, instr: rd});
        end

        if (m_out && rv) begin
            m_out  = 1'b0;
            m_drop = 1'b0;
        end else if (m_out) begin
            if (fl) m_drop = 1'b1;
            m_wait--;
        end

        if (fl)         pc_next = redirect_pc;
        else if (m_req) pc_next = pc + 32'd4;
        else            pc_next = pc;

        if (issue) begin
            m_out  = 1'b1;
            m_drop = 1'b0;
            m_wait = int'($urandom_range(lat_lo, lat_hi));
            m_addr = pc;
        end
        m_req = issue;
        pc    = pc_next;

        @(negedge clk);
    endtask

    task automatic run_until_req(input string tag);
        int guard;
        guard = 0;
        while (!m_req && guard < 60) begin
            do_cycle();
            guard++;
        end
        if (!m_req) check_eq({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    initial begin
        int n0;
        int guard;

        bus.pc_addr    = '0;
        bus.flush      = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        bus.dec_ready  = 1'b0;
        p_flush = 0; p_ready = 0; p_stray = 0; lat_lo = 1; lat_hi = 1;
        f_flush = 0; f_ready = 0; f_stray = 0;
        fix_data = 1'b1; fixed_rdata = 32'h2002_0005;
        rand_redirect = 1'b0; redirect_pc = 32'h40;
        pc = 32'h0;
        model_reset();

        #1 rst_n = 1'b0;
        #1 check_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Single fetch with decode stalled, then fill to capacity.
        repeat (3) do_cycle();
        check_eq("sf_dec_valid",  64'(bus.dec_valid),  64'd1);
        check_eq("sf_dec_instr",  64'(bus.dec_instr),  64'h2002_0005);
        check_eq("sf_dec_pc",     64'(bus.dec_pc),     64'h0);
        check_eq("sf_fifo_count", 64'(bus.fifo_count), 64'd1);
        repeat (14) do_cycle();
        check_eq("fill_reqs",  64'(n_req),          64'd4);
        check_eq("fill_count", 64'(bus.fifo_count), 64'd4);
        check_eq("fill_noreq", 64'(bus.mem_req),    64'd0);
        n0 = n_req;
        f_ready = 1'b1;
        repeat (8) do_cycle();
        check_eq("extra_req", 64'(n_req - n0), 64'd1);

        // Streaming with decode always ready.
        fix_data = 1'b0;
        p_ready  = 100;
        repeat (20) do_cycle();

        // Flush one cycle after a request with a 3-cycle memory.
        lat_lo = 3; lat_hi = 3; redirect_pc = 32'h40;
        run_until_req("fl_pre");
        do_cycle();
        f_flush = 1'b1;
        do_cycle();
        check_eq("flush_empty", 64'(bus.fifo_count), 64'd0);
        run_until_req("fl_post");
        check_eq("redirect_req",  64'(bus.mem_req),  64'd1);
        check_eq("redirect_addr", 64'(bus.mem_addr), 64'h40);

        // Flush coinciding with a response and a pop while two entries are held.
        lat_lo = 1; lat_hi = 1; p_ready = 0;
        f_flush = 1'b1;
        do_cycle();
        guard = 0;
        while (!(mq.size() == 2 && m_out && !m_drop && m_wait == 0) && guard < 60) begin
            do_cycle();
            guard++;
        end
        if (guard >= 60) check_eq("sim_setup_timeout", 64'd0, 64'd1);
        f_flush = 1'b1;
        f_ready = 1'b1;
        do_cycle();
        check_eq("sim_count", 64'(bus.fifo_count), 64'd0);
        check_eq("sim_noreq", 64'(bus.mem_req),    64'd0);
        do_cycle();
        check_eq("sim_idle_issue", 64'(bus.mem_req), 64'd1);

        // Randomised traffic.
        p_flush = 6; p_ready = 60; p_stray = 10; lat_lo = 1; lat_hi = 4;
        rand_redirect = 1'b1;
        repeat (400) do_cycle();

        // Asynchronous reset while a request is outstanding.
        guard = 0;
        while (!(m_out && !m_drop) && guard < 60) begin
            do_cycle();
            guard++;
        end
        if (guard >= 60) check_eq("mid_rst_setup_timeout", 64'd0, 64'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("mid_rst");
        model_reset();
        pc = 32'h100;
        p_flush = 0;
        @(negedge clk);
        rst_n   = 1'b1;
        f_stray = 1'b1;
        do_cycle();
        check_eq("post_rst_req",   64'(bus.mem_req),    64'd1);
        check_eq("post_rst_addr",  64'(bus.mem_addr),   64'h100);
        check_eq("post_rst_count", 64'(bus.fifo_count), 64'd0);
        p_flush = 6;
        repeat (300) do_cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
